// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants and state encoding for the UART command decoder.
// Command codes, operand register addresses and FSM states live here.
package uart_cmd_decoder_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_OP_A     = 4'd5,
    S_OP_B     = 4'd6,
    S_ALU_FUN  = 4'd7,
    S_ALU_WAIT = 4'd8,
    S_PUSH_LO  = 4'd9,
    S_PUSH_HI  = 4'd10
  } state_t;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bus bundle between the command decoder and its neighbours (RX sync,
// register file, ALU, TX FIFO). slave = decoder side, master = environment.
interface uart_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_Valid;
  logic                    FIFO_FULL;
  logic [ADDR_WIDTH-1:0]   Address;
  logic                    WrEn;
  logic                    RdEn;
  logic [DATA_WIDTH-1:0]   WrData;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_EN;
  logic [DATA_WIDTH-1:0]   WR_DATA;
  logic                    WR_INC;
  logic                    CTRL_BUSY;

  modport slave (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, WR_DATA, WR_INC, CTRL_BUSY
  );

  modport master (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, WR_DATA, WR_INC, CTRL_BUSY
  );

endinterface

// File: rtl/uart_cmd_decoder.sv
// Framed-command parser: turns RX bytes into register-file / ALU strobes and
// pushes read data or ALU results into the TX FIFO. All outputs registered.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic CLK,
  input  logic RST,
  uart_cmd_decoder_if.slave bus
);

  state_t r_state, w_next;

  logic [2*DATA_WIDTH-1:0] r_resp;
  logic                    r_two;

  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wrdata, w_wrdata;
  logic [FUN_WIDTH-1:0]  r_fun, w_fun;
  logic [DATA_WIDTH-1:0] r_txdata, w_txdata;
  logic r_wr_en, w_wr_en, r_rd_en, w_rd_en, r_alu_en, w_alu_en;
  logic r_wr_inc, w_wr_inc, r_clk_en, w_clk_en, r_busy, w_busy;

  logic w_vld, w_cmd_wr, w_cmd_rd, w_cmd_op, w_cmd_nop;

  assign w_vld     = bus.RX_D_VLD;
  assign w_cmd_wr  = (bus.RX_P_DATA == DATA_WIDTH'(CMD_WR));
  assign w_cmd_rd  = (bus.RX_P_DATA == DATA_WIDTH'(CMD_RD));
  assign w_cmd_op  = (bus.RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP));
  assign w_cmd_nop = (bus.RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_vld) begin
          if      (w_cmd_wr)  w_next = S_WR_ADDR;
          else if (w_cmd_rd)  w_next = S_RD_ADDR;
          else if (w_cmd_op)  w_next = S_OP_A;
          else if (w_cmd_nop) w_next = S_ALU_FUN;
        end
      end
      S_WR_ADDR:  if (w_vld) w_next = S_WR_DATA;
      S_WR_DATA:  if (w_vld) w_next = S_IDLE;
      S_RD_ADDR:  if (w_vld) w_next = S_RD_WAIT;
      S_RD_WAIT:  if (bus.RdData_Valid) w_next = S_PUSH_LO;
      S_OP_A:     if (w_vld) w_next = S_OP_B;
      S_OP_B:     if (w_vld) w_next = S_ALU_FUN;
      S_ALU_FUN:  if (w_vld) w_next = S_ALU_WAIT;
      S_ALU_WAIT: if (bus.OUT_Valid) w_next = S_PUSH_LO;
      S_PUSH_LO:  if (!bus.FIFO_FULL) w_next = r_two ? S_PUSH_HI : S_IDLE;
      S_PUSH_HI:  if (!bus.FIFO_FULL) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; data fields hold between strobes.
  always_comb begin
    w_wr_en  = 1'b0;
    w_rd_en  = 1'b0;
    w_alu_en = 1'b0;
    w_wr_inc = 1'b0;
    w_addr   = r_addr;
    w_wrdata = r_wrdata;
    w_fun    = r_fun;
    w_txdata = r_txdata;
    w_clk_en = (w_next == S_ALU_FUN) || (w_next == S_ALU_WAIT);
    w_busy   = (w_next != S_IDLE);
    case (r_state)
      S_WR_ADDR: if (w_vld) w_addr = bus.RX_P_DATA[ADDR_WIDTH-1:0];
      S_WR_DATA: if (w_vld) begin
        w_wrdata = bus.RX_P_DATA;
        w_wr_en  = 1'b1;
      end
      S_RD_ADDR: if (w_vld) begin
        w_addr  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        w_rd_en = 1'b1;
      end
      S_OP_A: if (w_vld) begin
        w_addr   = ADDR_WIDTH'(OPA_ADDR);
        w_wrdata = bus.RX_P_DATA;
        w_wr_en  = 1'b1;
      end
      S_OP_B: if (w_vld) begin
        w_addr   = ADDR_WIDTH'(OPB_ADDR);
        w_wrdata = bus.RX_P_DATA;
        w_wr_en  = 1'b1;
      end
      S_ALU_FUN: if (w_vld) begin
        w_fun    = bus.RX_P_DATA[FUN_WIDTH-1:0];
        w_alu_en = 1'b1;
      end
      S_PUSH_LO: if (!bus.FIFO_FULL) begin
        w_txdata = r_resp[DATA_WIDTH-1:0];
        w_wr_inc = 1'b1;
      end
      S_PUSH_HI: if (!bus.FIFO_FULL) begin
        w_txdata = r_resp[2*DATA_WIDTH-1:DATA_WIDTH];
        w_wr_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr   <= '0;
      r_wrdata <= '0;
      r_fun    <= '0;
      r_txdata <= '0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_alu_en <= 1'b0;
      r_wr_inc <= 1'b0;
      r_clk_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_addr   <= w_addr;
      r_wrdata <= w_wrdata;
      r_fun    <= w_fun;
      r_txdata <= w_txdata;
      r_wr_en  <= w_wr_en;
      r_rd_en  <= w_rd_en;
      r_alu_en <= w_alu_en;
      r_wr_inc <= w_wr_inc;
      r_clk_en <= w_clk_en;
      r_busy   <= w_busy;
    end
  end

  // Response capture: read data is a one-byte response, ALU result two bytes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_resp <= '0;
      r_two  <= 1'b0;
    end else if (r_state == S_RD_WAIT && bus.RdData_Valid) begin
      r_resp <= {{DATA_WIDTH{1'b0}}, bus.RdData};
      r_two  <= 1'b0;
    end else if (r_state == S_ALU_WAIT && bus.OUT_Valid) begin
      r_resp <= bus.ALU_OUT;
      r_two  <= 1'b1;
    end
  end

  assign bus.Address   = r_addr;
  assign bus.WrEn      = r_wr_en;
  assign bus.RdEn      = r_rd_en;
  assign bus.WrData    = r_wrdata;
  assign bus.ALU_EN    = r_alu_en;
  assign bus.ALU_FUN   = r_fun;
  assign bus.CLK_EN    = r_clk_en;
  assign bus.WR_DATA   = r_txdata;
  assign bus.WR_INC    = r_wr_inc;
  assign bus.CTRL_BUSY = r_busy;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: transaction-level model (frame queue + response
// queue) checked every cycle, plus directed scenarios with literal expectations.
module tb_uart_cmd_decoder;

  logic CLK, RST;
  uart_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bif();

  uart_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .bus(bif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] frame[$];
  logic [7:0] resp_q[$];
  bit wait_rd, wait_alu, model_ready;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wrdata, e_txdata;
  bit e_wren, e_rden, e_aluen, e_wrinc, e_clken, e_busy;

  task automatic model_step(input bit rst, input bit vld, input logic [7:0] b,
                            input bit rdv, input logic [7:0] rdd,
                            input bit outv, input logic [15:0] aout, input bit full);
    e_wren = 0; e_rden = 0; e_aluen = 0; e_wrinc = 0;
    if (rst) begin
      frame.delete(); resp_q.delete();
      wait_rd = 0; wait_alu = 0;
      e_addr = 0; e_fun = 0; e_wrdata = 0; e_txdata = 0;
    end else begin
      if (resp_q.size() != 0) begin
        if (!full) begin
          e_wrinc  = 1;
          e_txdata = resp_q.pop_front();
        end
      end else if (wait_rd) begin
        if (rdv) begin resp_q.push_back(rdd); wait_rd = 0; end
      end else if (wait_alu) begin
        if (outv) begin
          resp_q.push_back(aout[7:0]);
          resp_q.push_back(aout[15:8]);
          wait_alu = 0;
        end
      end else if (vld) begin
        frame.push_back(b);
        case (frame[0])
          8'hAA: begin
            if (frame.size() == 2) e_addr = b[3:0];
            else if (frame.size() == 3) begin
              e_wrdata = b; e_wren = 1; frame.delete();
            end
          end
          8'hBB: if (frame.size() == 2) begin
            e_addr = b[3:0]; e_rden = 1; frame.delete(); wait_rd = 1;
          end
          8'hCC: begin
            if (frame.size() == 2)      begin e_addr = 4'd0; e_wrdata = b; e_wren = 1; end
            else if (frame.size() == 3) begin e_addr = 4'd1; e_wrdata = b; e_wren = 1; end
            else if (frame.size() == 4) begin
              e_fun = b[3:0]; e_aluen = 1; frame.delete(); wait_alu = 1;
            end
          end
          8'hDD: if (frame.size() == 2) begin
            e_fun = b[3:0]; e_aluen = 1; frame.delete(); wait_alu = 1;
          end
          default: frame.delete();
        endcase
      end
    end
    e_clken = wait_alu || (frame.size() > 0 &&
              (frame[0] == 8'hDD || (frame[0] == 8'hCC && frame.size() >= 3)));
    e_busy  = (frame.size() > 0) || wait_rd || wait_alu || (resp_q.size() > 0);
  endtask

  // Strobe logs for the directed literal checks
  logic [11:0] wr_log[$];
  logic [3:0]  rd_log[$];
  logic [3:0]  alu_log[$];
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];

  initial begin
    forever begin
      @(posedge CLK);
      model_step(RST, bif.RX_D_VLD, bif.RX_P_DATA, bif.RdData_Valid, bif.RdData,
                 bif.OUT_Valid, bif.ALU_OUT, bif.FIFO_FULL);
      if (RST) model_ready = 1;
      @(negedge CLK);
      cyc++;
      if (model_ready) begin
        chk("WrEn",      bif.WrEn,      e_wren);
        chk("RdEn",      bif.RdEn,      e_rden);
        chk("ALU_EN",    bif.ALU_EN,    e_aluen);
        chk("WR_INC",    bif.WR_INC,    e_wrinc);
        chk("CLK_EN",    bif.CLK_EN,    e_clken);
        chk("CTRL_BUSY", bif.CTRL_BUSY, e_busy);
        chk("Address",   bif.Address,   e_addr);
        chk("WrData",    bif.WrData,    e_wrdata);
        chk("ALU_FUN",   bif.ALU_FUN,   e_fun);
        chk("WR_DATA",   bif.WR_DATA,   e_txdata);
        if (bif.WrEn === 1'b1)   wr_log.push_back({bif.Address, bif.WrData});
        if (bif.RdEn === 1'b1)   rd_log.push_back(bif.Address);
        if (bif.ALU_EN === 1'b1) alu_log.push_back(bif.ALU_FUN);
        if (bif.WR_INC === 1'b1) begin tx_log.push_back(bif.WR_DATA); tx_cyc.push_back(cyc); end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); alu_log.delete(); tx_log.delete(); tx_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bif.RX_P_DATA = b;
    bif.RX_D_VLD  = 1'b1;
    tick();
    bif.RX_D_VLD  = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic bit sig(input int which);
    case (which)
      0: return bif.WrEn === 1'b1;
      1: return bif.RdEn === 1'b1;
      2: return bif.ALU_EN === 1'b1;
      default: return bif.WR_INC === 1'b1;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string nm);
    int n = 0;
    while (!sig(which) && n < 50) begin tick(); n++; end
    chk({"timeout ", nm}, (n < 50), 1);
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    bif.RdData = d; bif.RdData_Valid = 1'b1;
    tick();
    bif.RdData_Valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] d);
    bif.ALU_OUT = d; bif.OUT_Valid = 1'b1;
    tick();
    bif.OUT_Valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bif.RX_P_DATA = 0; bif.RX_D_VLD = 0; bif.RdData = 0; bif.RdData_Valid = 0;
    bif.ALU_OUT = 0; bif.OUT_Valid = 0; bif.FIFO_FULL = 0;
    repeat (3) tick();
    chk("reset busy", bif.CTRL_BUSY, 0);
    chk("reset outputs", {bif.WrEn, bif.RdEn, bif.ALU_EN, bif.WR_INC, bif.CLK_EN,
                          bif.Address, bif.WrData, bif.ALU_FUN, bif.WR_DATA}, 0);
    RST = 1'b0;
    tick();

    // register write
    clear_logs();
    send_byte(8'hAA, 3); send_byte(8'h05, 3); send_byte(8'h3C, 3);
    chk("wr count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("wr addr/data", wr_log[0], 12'h53C);
    chk("wr other strobes", rd_log.size() + alu_log.size() + tx_log.size(), 0);
    chk("wr busy after", bif.CTRL_BUSY, 0);

    // register read
    clear_logs();
    send_byte(8'hBB, 0); send_byte(8'h07, 0);
    wait_sig(1, "RdEn");
    repeat (3) tick();
    pulse_rd(8'h9E);
    repeat (4) tick();
    chk("rd count", rd_log.size(), 1);
    if (rd_log.size() > 0) chk("rd addr", rd_log[0], 7);
    chk("rd tx count", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("rd tx data", tx_log[0], 8'h9E);
    chk("rd busy after", bif.CTRL_BUSY, 0);

    // ALU with operands
    clear_logs();
    send_byte(8'hCC, 1); send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h01, 0);
    wait_sig(2, "ALU_EN");
    chk("alu clk_en on", bif.CLK_EN, 1);
    repeat (2) tick();
    chk("alu clk_en wait", bif.CLK_EN, 1);
    pulse_alu(16'h0046);
    repeat (5) tick();
    chk("alu wr count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("alu opA", wr_log[0], 12'h012);
      chk("alu opB", wr_log[1], 12'h134);
    end
    if (alu_log.size() > 0) chk("alu fun", alu_log[0], 1);
    chk("alu tx count", tx_log.size(), 2);
    if (tx_log.size() == 2) chk("alu tx bytes", {tx_log[0], tx_log[1]}, 16'h4600);
    chk("alu clk_en off", bif.CLK_EN, 0);

    // ALU without operands, FIFO full backpressure
    clear_logs();
    send_byte(8'hDD, 0); send_byte(8'h02, 0);
    wait_sig(2, "ALU_EN2");
    tick();
    bif.FIFO_FULL = 1'b1;
    pulse_alu(16'hABCD);
    repeat (5) tick();
    chk("full no push", tx_log.size(), 0);
    chk("full busy", bif.CTRL_BUSY, 1);
    bif.FIFO_FULL = 1'b0;
    repeat (5) tick();
    chk("full tx count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("full tx bytes", {tx_log[0], tx_log[1]}, 16'hCDAB);
      chk("full consecutive", tx_cyc[1] - tx_cyc[0], 1);
    end

    // ignored bytes
    clear_logs();
    send_byte(8'h55, 2);
    chk("junk busy", bif.CTRL_BUSY, 0);
    send_byte(8'hBB, 0); send_byte(8'h02, 0);
    wait_sig(1, "RdEn2");
    send_byte(8'hAA, 2);
    chk("rdwait busy", bif.CTRL_BUSY, 1);
    chk("rdwait strobes", wr_log.size() + alu_log.size() + tx_log.size(), 0);
    pulse_rd(8'h11);
    repeat (4) tick();
    chk("rdwait tx count", tx_log.size(), 1);

    // reset mid-frame
    clear_logs();
    send_byte(8'hAA, 1); send_byte(8'h03, 1);
    RST = 1'b1;
    tick();
    chk("midrst outputs", {bif.WrEn, bif.RdEn, bif.ALU_EN, bif.WR_INC, bif.CLK_EN, bif.CTRL_BUSY,
                           bif.Address, bif.WrData, bif.ALU_FUN, bif.WR_DATA}, 0);
    RST = 1'b0;
    tick();
    send_byte(8'hBB, 0); send_byte(8'h03, 0);
    wait_sig(1, "RdEn3");
    chk("midrst rd addr", bif.Address, 3);
    chk("midrst no wr", wr_log.size(), 0);
    pulse_rd(8'h5A);
    repeat (4) tick();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bif.RX_D_VLD  = ($urandom % 3 == 0);
      case ($urandom % 6)
        0: bif.RX_P_DATA = 8'hAA;
        1: bif.RX_P_DATA = 8'hBB;
        2: bif.RX_P_DATA = 8'hCC;
        3: bif.RX_P_DATA = 8'hDD;
        default: bif.RX_P_DATA = 8'($urandom);
      endcase
      bif.RdData_Valid = ($urandom % 6 == 0);
      bif.RdData       = 8'($urandom);
      bif.OUT_Valid    = ($urandom % 6 == 0);
      bif.ALU_OUT      = 16'($urandom);
      bif.FIFO_FULL    = ($urandom % 4 == 0);
      RST              = ($urandom % 300 == 0);
      tick();
    end
    bif.RX_D_VLD = 0; bif.RdData_Valid = 0; bif.OUT_Valid = 0; bif.FIFO_FULL = 0; RST = 0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Reference-clock-domain command controller. Sits directly downstream of the UART RX data synchronizer.
- Consumes each synchronized RX byte with its one-cycle valid pulse and parses framed commands.
- Drives register-file write/read strobes and ALU operation/clock-gate enables.
- Pushes response bytes (read data, ALU result) into the TX async FIFO.

Parameters:
- DATA_WIDTH, 8, width of RX byte, register data and FIFO write data
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
- FUN_WIDTH, 4, ALU function code width; taken from the low bits of the function byte

Ports:
- CLK  in  1  reference clock
- RST  in  1  synchronous active-high reset
- RX_P_DATA  in  DATA_WIDTH  synchronized RX byte; valid only when RX_D_VLD=1
- RX_D_VLD  in  1  single-cycle byte-valid pulse from the sync stage
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  register-file read data valid, single-cycle
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_Valid  in  1  ALU result valid, single-cycle
- FIFO_FULL  in  1  TX FIFO full
- Address  out  ADDR_WIDTH  register-file address
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- WrData  out  DATA_WIDTH  register-file write data
- ALU_EN  out  1  ALU start strobe
- ALU_FUN  out  FUN_WIDTH  ALU function
- CLK_EN  out  1  ALU clock-gate enable
- WR_DATA  out  DATA_WIDTH  TX FIFO write data
- WR_INC  out  1  TX FIFO push strobe
- CTRL_BUSY  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous and active-high (RST).
- Reset: FSM to IDLE. All outputs 0. Capture registers cleared. Applying RST mid-frame aborts the frame with no strobes issued.
- Outputs are registered. Every strobe (WrEn, RdEn, ALU_EN, WR_INC) is exactly one cycle wide and asserts the cycle after its triggering event. Address, WrData, ALU_FUN and WR_DATA are valid in that same cycle.
- Command codes:
  - 0xAA: register write; frame = cmd, addr, data
  - 0xBB: register read; frame = cmd, addr
  - 0xCC: ALU with operands; frame = cmd, A, B, fun
  - 0xDD: ALU without operands; frame = cmd, fun
- Any other byte in IDLE is ignored; FSM stays in IDLE.
- States and transitions. All byte-consuming transitions occur only on RX_D_VLD=1; otherwise the state holds.
  - IDLE:
    - 0xAA -> WR_ADDR
    - 0xBB -> RD_ADDR
    - 0xCC -> OP_A
    - 0xDD -> ALU_FUN_S
  - WR_ADDR: latch Address=byte[ADDR_WIDTH-1:0] -> WR_DATA.
  - WR_DATA: WrData=byte, WrEn pulse -> IDLE.
  - RD_ADDR: latch Address, RdEn pulse -> RD_WAIT.
  - RD_WAIT: on RdData_Valid, capture RdData into the response register -> PUSH_LO (single-byte response).
  - OP_A: WrEn pulse with Address=0, WrData=byte -> OP_B.
  - OP_B: WrEn pulse with Address=1, WrData=byte -> ALU_FUN_S.
  - ALU_FUN_S: on entry CLK_EN=1. On byte: ALU_FUN=byte[FUN_WIDTH-1:0], ALU_EN pulse -> ALU_WAIT.
  - ALU_WAIT: CLK_EN=1. On OUT_Valid, capture ALU_OUT -> PUSH_LO (two-byte response). CLK_EN drops when leaving ALU_WAIT.
  - PUSH_LO: when FIFO_FULL=0, WR_DATA=response[DATA_WIDTH-1:0], WR_INC pulse. Then -> PUSH_HI if two-byte, else -> IDLE. While full, hold with no push.
  - PUSH_HI: same rule with the upper byte -> IDLE.
- Edge cases:
  - RX_D_VLD while in RD_WAIT, ALU_WAIT or PUSH_*: byte is dropped. No state change, no strobe.
  - RdData_Valid/OUT_Valid arriving outside its wait state is ignored.
  - OUT_Valid coincident with RX_D_VLD in ALU_WAIT: result is captured, the byte is dropped.
  - FIFO_FULL rising in the same cycle a push would issue: the push is suppressed and retried.
  - No timeout; a stalled wait is cleared only by RST.
- CTRL_BUSY = (state != IDLE), registered with the state.

Decomposition:
- Shared package:
  - command code constants CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP
  - state encoding localparams
  - operand addresses OPA_ADDR=0, OPB_ADDR=1
- Single flat module. The response push sequencer (PUSH_LO/PUSH_HI) may be factored as sub-module resp_pusher but is not required.

Test Plan:
- Bytes AA,05,3C, each as a 1-cycle RX_D_VLD spaced 4 cycles apart -> one WrEn pulse with Address=5, WrData=0x3C. No other strobes. CTRL_BUSY low after.
- Bytes BB,07; RdData=0x9E with RdData_Valid 3 cycles after RdEn -> RdEn pulse with Address=7; one WR_INC with WR_DATA=0x9E; returns to IDLE.
- Bytes CC,12,34,01; OUT_Valid with ALU_OUT=0x0046 -> WrEn addr0=0x12 then addr1=0x34; ALU_EN with ALU_FUN=1; CLK_EN high from ALU_FUN_S through OUT_Valid; pushes 0x46 then 0x00.
- Byte DD,02 with FIFO_FULL=1 held 5 cycles after OUT_Valid (ALU_OUT=0xABCD) -> no WR_INC while full. After release, pushes 0xCD then 0xAB on consecutive cycles.
- Byte 0x55 in IDLE, then RX_D_VLD during RD_WAIT -> both ignored, no strobes, state unchanged.
- RST asserted after AA,03 (mid-frame) -> all outputs 0 next cycle. A following BB,03 decodes normally.
